// File: rtl/tt_capture_pkg.sv
// Shared types and sizing for the truth-table capture sweep.
package tt_capture_pkg;
  typedef enum logic [1:0] {IDLE, SWEEP, EMIT} state_e;

  localparam int N_VARS_DFLT = 7;
  localparam int TT_BITS     = 1 << N_VARS_DFLT;
  localparam int NIBBLES     = TT_BITS / 4;

  function automatic int tt_bits(input int n);
    return 1 << n;
  endfunction
endpackage

// File: rtl/tt_capture_sweep_if.sv
// Hex-nibble valid/ready stream carrying the captured truth table.
interface tt_capture_sweep_if;
  logic [3:0] nib_data;
  logic       nib_valid;
  logic       nib_ready;
  logic       nib_last;

  modport master (output nib_data, nib_valid, nib_last, input nib_ready);
  modport slave  (input nib_data, nib_valid, nib_last, output nib_ready);
endinterface

// File: rtl/tt_nibble_serializer.sv
// Loads a captured truth table and shifts it out MS nibble first over valid/ready.
module tt_nibble_serializer
  import tt_capture_pkg::*;
#(
  parameter int NIB = NIBBLES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [4*NIB-1:0]   tbl,
  tt_capture_sweep_if.master nib,
  output logic               fin
);
  localparam int KW = $clog2(NIB) + 1;

  logic [4*NIB-1:0] sh;
  logic [KW-1:0]    k;
  logic             vld;
  logic             xfer;

  assign xfer = vld & nib.nib_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh  <= '0;
      k   <= '0;
      vld <= 1'b0;
    end else if (load) begin
      sh  <= tbl;
      k   <= KW'(NIB - 1);
      vld <= 1'b1;
    end else if (xfer) begin
      // Shifting in zeros leaves nib_data at 0 once the table is drained.
      sh <= sh << 4;
      k  <= (k == '0) ? '0 : k - 1'b1;
      if (k == '0) vld <= 1'b0;
    end
  end

  assign nib.nib_data  = sh[4*NIB-1 -: 4];
  assign nib.nib_valid = vld;
  assign nib.nib_last  = vld && (k == '0);
  assign fin           = xfer && (k == '0);
endmodule

// File: rtl/tt_capture_sweep.sv
// Sweeps all input vectors of a combinational function, captures its truth table, streams it as hex.
// Optional TT_CAPTURE_ONESCNT_EN adds a ones_cnt output with the table's population count.
module tt_capture_sweep
  import tt_capture_pkg::*;
#(
  parameter int N_VARS        = N_VARS_DFLT,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [N_VARS-1:0]  x_out,
  input  logic               func_in,
  output logic               busy,
  output logic               done,
`ifdef TT_CAPTURE_ONESCNT_EN
  output logic [N_VARS:0]    ones_cnt,
`endif
  tt_capture_sweep_if.master nib
);
  localparam int              TW          = tt_bits(N_VARS);
  localparam int              NW          = TW / 4;
  localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE_CYCLES);
  localparam logic [N_VARS:0] MT_LAST     = {1'b0, {N_VARS{1'b1}}};

  state_e          st;
  logic [N_VARS:0] mt;
  logic [3:0]      settle;
  logic [TW-1:0]   tbl, tbl_nxt;
  logic            sample, load, fin;

  assign sample = (st == SWEEP) && (settle == SETTLE_LAST);
  assign load   = sample && (mt == MT_LAST);
  assign x_out  = mt[N_VARS-1:0];

  // Merge the current sample so the final minterm reaches the serializer on the same edge.
  always_comb begin
    tbl_nxt = tbl;
    if (sample) tbl_nxt[mt[N_VARS-1:0]] = func_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st     <= IDLE;
      mt     <= '0;
      settle <= '0;
      tbl    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
`ifdef TT_CAPTURE_ONESCNT_EN
      ones_cnt <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (st)
        IDLE: if (start) begin
          st     <= SWEEP;
          mt     <= '0;
          settle <= '0;
          tbl    <= '0;
          busy   <= 1'b1;
`ifdef TT_CAPTURE_ONESCNT_EN
          ones_cnt <= '0;
`endif
        end
        SWEEP: begin
          tbl <= tbl_nxt;
          if (sample) begin
            settle <= '0;
`ifdef TT_CAPTURE_ONESCNT_EN
            ones_cnt <= ones_cnt + {{N_VARS{1'b0}}, func_in};
`endif
            if (mt == MT_LAST) begin
              mt <= '0;
              st <= EMIT;
            end else begin
              mt <= mt + 1'b1;
            end
          end else begin
            settle <= settle + 1'b1;
          end
        end
        EMIT: if (fin) begin
          st   <= IDLE;
          busy <= 1'b0;
          done <= 1'b1;
        end
        default: st <= IDLE;
      endcase
    end
  end

  tt_nibble_serializer #(.NIB(NW)) u_ser (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .tbl   (tbl_nxt),
    .nib   (nib),
    .fin   (fin)
  );
endmodule

// File: tb/tb_tt_capture_sweep.sv
// Runs SETTLE_CYCLES=1 and =3 instances side by side against a truth-table model and nibble scoreboard.
module tb_tt_capture_sweep;
  localparam int NV = 7;
  localparam int TB = 1 << NV;
  localparam int NN = TB / 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  int           mode = 0;
  logic [127:0] rtab = '0;
  int           rmode [2];

  logic          st [2];
  logic [NV-1:0] xo [2];
  logic          fi [2];
  logic          bz [2];
  logic          dn [2];
  logic          nv [2];
  logic [3:0]    nd [2];
  logic          nl [2];
  logic [NV:0]   ocm [2];
  int            done_cnt [2];
  logic [4:0]    expq [2][$];

  // Reference function: the candidate network evaluated straight from its definition.
  function automatic logic fmodel(input int m, input logic [NV-1:0] xv, input logic [127:0] rt);
    case (m)
      0: return xv[0];
      1: return &xv;
      2: return xv[6];
      3: return 1'b1;
      5: return rt[xv];
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input bit ok, input string nm, input longint act, input longint exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : gi
    localparam int SC = (g == 0) ? 1 : 3;
    tt_capture_sweep_if nif ();
    logic [NV:0] oc;
    int rc = 0;

    assign fi[g]  = fmodel(mode, xo[g], rtab);
    assign nv[g]  = nif.nib_valid;
    assign nd[g]  = nif.nib_data;
    assign nl[g]  = nif.nib_last;
`ifdef TT_CAPTURE_ONESCNT_EN
    assign ocm[g] = oc;
`else
    assign oc     = '0;
    assign ocm[g] = oc;
`endif

    tt_capture_sweep #(.N_VARS(NV), .SETTLE_CYCLES(SC)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (st[g]),
      .x_out   (xo[g]),
      .func_in (fi[g]),
      .busy    (bz[g]),
      .done    (dn[g]),
`ifdef TT_CAPTURE_ONESCNT_EN
      .ones_cnt(oc),
`endif
      .nib     (nif)
    );

    initial begin
      nif.nib_ready = 1'b0;
      forever begin
        @(posedge clk); #1;
        case (rmode[g])
          0: nif.nib_ready = 1'b1;
          1: nif.nib_ready = (rc % 3 == 0);
          default: nif.nib_ready = 1'($urandom_range(0, 1));
        endcase
        rc++;
      end
    end

    // Monitor: pops the scoreboard on each transfer and watches sweep timing.
    bit         stalled = 0;
    bit         lastx = 0;
    logic [3:0] held = '0;
    int         run = 0;
    int         slen = 0;
    logic [NV-1:0] px = '0;
    logic [4:0] e;
    initial forever begin
      @(negedge clk);
      if (!rst_n) begin
        expq[g].delete();
        stalled = 0; lastx = 0; run = 0; slen = 0;
      end else begin
        if (dn[g]) begin
          done_cnt[g]++;
          chk(lastx, "done_after_last", 0, 1);
          chk(bz[g] == 1'b0, "busy_low_at_done", bz[g], 0);
        end
        lastx = 0;
        if (stalled)
          chk(nif.nib_valid && nif.nib_data == held, "stall_hold", nif.nib_data, held);
        if (bz[g] && !nif.nib_valid) begin
          slen++;
          if (run > 0 && xo[g] != px) begin
            chk(run == SC + 1, "x_hold", run, SC + 1);
            chk(xo[g] == NV'(px + 1'b1), "x_step", xo[g], NV'(px + 1'b1));
            run = 1;
          end else begin
            run++;
          end
          px = xo[g];
        end
        if (nif.nib_valid && slen > 0) begin
          chk(slen == TB * (SC + 1), "sweep_len", slen, TB * (SC + 1));
          chk(run == SC + 1, "x_hold_last", run, SC + 1);
          slen = 0; run = 0;
        end
        if (nif.nib_valid && nif.nib_ready) begin
          if (expq[g].size() == 0) begin
            chk(0, "unexpected_nibble", nif.nib_data, 0);
          end else begin
            e = expq[g].pop_front();
            chk(nif.nib_data == e[3:0], "nib_data", nif.nib_data, e[3:0]);
            chk(nif.nib_last == e[4], "nib_last", nif.nib_last, e[4]);
          end
          lastx = nif.nib_last;
          stalled = 0;
        end else if (nif.nib_valid) begin
          stalled = 1;
          held = nif.nib_data;
        end else begin
          stalled = 0;
        end
      end
    end
  end

  task automatic run(input int m, input int rm, input bit spur);
    logic [3:0] n;
    int ones;
    int d0 [2];
    bit ep [2];
    mode = m;
    if (m == 5) rtab = {$urandom, $urandom, $urandom, $urandom};
    ones = 0;
    for (int i = 0; i < TB; i++) ones += int'(fmodel(m, NV'(i), rtab));
    for (int g = 0; g < 2; g++) begin
      rmode[g] = rm;
      d0[g] = done_cnt[g];
      ep[g] = 0;
      for (int k = NN - 1; k >= 0; k--) begin
        for (int b = 0; b < 4; b++) n[b] = fmodel(m, NV'(4 * k + b), rtab);
        expq[g].push_back({k == 0, n});
      end
    end
    @(posedge clk); #1;
    st[0] = 1'b1; st[1] = 1'b1;
    for (int c = 0; c < 4000 && !(done_cnt[0] > d0[0] && done_cnt[1] > d0[1]); c++) begin
      @(posedge clk); #1;
      for (int g = 0; g < 2; g++) begin
        st[g] = 1'b0;
        if (spur && c == 20) st[g] = 1'b1;
        if (spur && nv[g] && !ep[g]) begin st[g] = 1'b1; ep[g] = 1; end
      end
    end
    st[0] = 1'b0; st[1] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    for (int g = 0; g < 2; g++) begin
      chk(done_cnt[g] == d0[g] + 1, "done_once", done_cnt[g] - d0[g], 1);
      chk(expq[g].size() == 0, "queue_drained", expq[g].size(), 0);
      chk(bz[g] == 1'b0 && nv[g] == 1'b0, "idle_after", {bz[g], nv[g]}, 0);
`ifdef TT_CAPTURE_ONESCNT_EN
      chk(ocm[g] == (NV+1)'(ones), "ones_cnt", ocm[g], ones);
`endif
    end
  endtask

  initial begin
    st[0] = 1'b0; st[1] = 1'b0;
    rmode[0] = 0; rmode[1] = 0;
    done_cnt[0] = 0; done_cnt[1] = 0;
    #12;
    for (int g = 0; g < 2; g++)
      chk({xo[g], bz[g], dn[g], nv[g], nd[g], nl[g], ocm[g]} == '0, "reset_outputs",
          {xo[g], bz[g], dn[g], nv[g], nd[g], nl[g]}, 0);
    @(posedge clk); #3 rst_n = 1'b1;

    run(0, 0, 0);   // x0 -> all 0xa
    run(1, 0, 0);   // AND -> 0x8 then zeros
    run(2, 0, 0);   // x6 -> 16x 0xf, 16x 0x0
    run(3, 1, 0);   // constant 1, ready 1-of-3
    run(5, 2, 1);   // random table, random ready, spurious starts
    run(0, 0, 1);   // spurious starts with free-running consumer

    // Abort mid-sweep, then confirm a fresh sweep carries nothing stale.
    mode = 3;
    @(posedge clk); #1;
    st[0] = 1'b1; st[1] = 1'b1;
    @(posedge clk); #1;
    st[0] = 1'b0; st[1] = 1'b0;
    for (int c = 0; c < 2000 && xo[0] != NV'(50); c++) begin
      @(posedge clk); #1;
    end
    chk(xo[0] == NV'(50), "reach_minterm50", xo[0], 50);
    #2 rst_n = 1'b0;
    #1;
    for (int g = 0; g < 2; g++)
      chk({xo[g], bz[g], dn[g], nv[g], nd[g], nl[g], ocm[g]} == '0, "async_reset_outputs",
          {xo[g], bz[g], dn[g], nv[g], nd[g], nl[g]}, 0);
    @(posedge clk); #3 rst_n = 1'b1;
    run(4, 0, 0);   // constant 0 after abort
    run(2, 2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
